// File: rtl/ibex_csr_redundant.sv
// Redundantly stored CSR: single copy, inverted shadow pair, or triple copy with
// majority vote, background scrub, error lock-out and a saturating minor-error counter.
module ibex_csr_redundant #(
   parameter int unsigned      Width       = 32,
   parameter int unsigned      RedMode     = 2,
   parameter logic [Width-1:0] ResetValue  = '0,
   parameter int unsigned      ErrCntWidth = 8
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   input  logic [Width-1:0]       wr_data_i,
   input  logic                   wr_en_i,
   input  logic                   err_cnt_clr_i,
   output logic [Width-1:0]       rd_data_o,
   output logic                   rd_error_o,
   output logic                   csr_new_maj_err_o,
   output logic                   csr_new_min_err_o,
   output logic                   csr_scrub_occurred_o,
   output logic [ErrCntWidth-1:0] err_cnt_o
);

   localparam logic [1:0] StIdle   = 2'd0;
   localparam logic [1:0] StScrub  = 2'd1;
   localparam logic [1:0] StLocked = 2'd2;

   // In shadow mode copy1 holds the inverted data.
   localparam logic [Width-1:0] ShadowMask = (RedMode == 1) ? '1 : '0;

   logic [Width-1:0]       copy0_q, copy1_q, copy2_q;
   logic [Width-1:0]       vote, load_val;
   logic [2:0]             diff;
   logic                   minor, major, load;
   logic [1:0]             state_q, state_d;
   logic                   maj_pulse_q, maj_pulse_d;
   logic                   scrub_pulse_q, scrub_pulse_d;
   logic [ErrCntWidth-1:0] err_cnt_q, err_cnt_d;

   always_comb begin
      vote  = copy0_q;
      diff  = '0;
      minor = 1'b0;
      major = 1'b0;
      if (RedMode == 2) begin
         vote  = (copy0_q & copy1_q) | (copy0_q & copy2_q) | (copy1_q & copy2_q);
         diff  = {|(copy2_q ^ vote), |(copy1_q ^ vote), |(copy0_q ^ vote)};
         major = (diff[0] & diff[1]) | (diff[0] & diff[2]) | (diff[1] & diff[2]);
         minor = (^diff) & ~major;
      end else if (RedMode == 1) begin
         major = (copy0_q != ~copy1_q);
      end
   end

   assign load     = wr_en_i | (state_q == StScrub);
   assign load_val = wr_en_i ? wr_data_i : vote;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         copy0_q <= ResetValue;
         copy1_q <= ResetValue ^ ShadowMask;
         copy2_q <= ResetValue;
      end else if (load) begin
         copy0_q <= load_val;
         copy1_q <= load_val ^ ShadowMask;
         copy2_q <= load_val;
      end
   end

   // Errors are only acted on when no write is pending; a write always returns to idle.
   always_comb begin
      state_d = state_q;
      if (RedMode == 0 || wr_en_i) begin
         state_d = StIdle;
      end else begin
         case (state_q)
            StIdle: begin
               if (major) begin
                  state_d = StLocked;
               end else if (minor) begin
                  state_d = StScrub;
               end
            end
            StScrub:  state_d = StIdle;
            StLocked: state_d = StLocked;
            default:  state_d = StIdle;
         endcase
      end
   end

   always_comb begin
      maj_pulse_d   = (state_q == StIdle) && (state_d == StLocked);
      scrub_pulse_d = (state_q == StScrub) && !wr_en_i;
      err_cnt_d     = err_cnt_q;
      if (err_cnt_clr_i) begin
         err_cnt_d = '0;
      end else if (state_q == StScrub && err_cnt_q != '1) begin
         err_cnt_d = err_cnt_q + ErrCntWidth'(1);
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q       <= StIdle;
         maj_pulse_q   <= 1'b0;
         scrub_pulse_q <= 1'b0;
         err_cnt_q     <= '0;
      end else begin
         state_q       <= state_d;
         maj_pulse_q   <= maj_pulse_d;
         scrub_pulse_q <= scrub_pulse_d;
         err_cnt_q     <= err_cnt_d;
      end
   end

   assign rd_data_o            = vote;
   assign rd_error_o           = (RedMode != 0) && ((state_q == StLocked) || major);
   assign csr_new_maj_err_o    = (RedMode != 0) && maj_pulse_q;
   assign csr_new_min_err_o    = (RedMode != 0) && (state_q == StScrub);
   assign csr_scrub_occurred_o = (RedMode != 0) && scrub_pulse_q;
   assign err_cnt_o            = (RedMode != 0) ? err_cnt_q : '0;

endmodule

// File: tb/tb_ibex_csr_redundant.sv
// Directed bench for ibex_csr_redundant: vector table for plain writes plus hand-built
// fault-injection sequences for scrub, lock-out, write priority, saturation and reset.
module tb_ibex_csr_redundant;

   localparam logic [31:0] RV = 32'hC3C3_0F0F;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] wr_data;
   logic        wr_en;
   logic        clr;

   logic [31:0] rd2, rd1, rd0, rds;
   logic        err2, err1, err0, errs;
   logic        maj2, maj1, maj0, majs;
   logic        min2, min1, min0, mins;
   logic        scr2, scr1, scr0, scrs;
   logic [7:0]  cnt2, cnt1, cnt0;
   logic [1:0]  cnts;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   ibex_csr_redundant #(.Width(32), .RedMode(2), .ResetValue(RV), .ErrCntWidth(8)) u_m2 (
      .clk_i(clk), .rst_i(rst), .wr_data_i(wr_data), .wr_en_i(wr_en), .err_cnt_clr_i(clr),
      .rd_data_o(rd2), .rd_error_o(err2), .csr_new_maj_err_o(maj2), .csr_new_min_err_o(min2),
      .csr_scrub_occurred_o(scr2), .err_cnt_o(cnt2));

   ibex_csr_redundant #(.Width(32), .RedMode(1), .ResetValue(RV), .ErrCntWidth(8)) u_m1 (
      .clk_i(clk), .rst_i(rst), .wr_data_i(wr_data), .wr_en_i(wr_en), .err_cnt_clr_i(clr),
      .rd_data_o(rd1), .rd_error_o(err1), .csr_new_maj_err_o(maj1), .csr_new_min_err_o(min1),
      .csr_scrub_occurred_o(scr1), .err_cnt_o(cnt1));

   ibex_csr_redundant #(.Width(32), .RedMode(0), .ResetValue(RV), .ErrCntWidth(8)) u_m0 (
      .clk_i(clk), .rst_i(rst), .wr_data_i(wr_data), .wr_en_i(wr_en), .err_cnt_clr_i(clr),
      .rd_data_o(rd0), .rd_error_o(err0), .csr_new_maj_err_o(maj0), .csr_new_min_err_o(min0),
      .csr_scrub_occurred_o(scr0), .err_cnt_o(cnt0));

   ibex_csr_redundant #(.Width(32), .RedMode(2), .ResetValue(RV), .ErrCntWidth(2)) u_sat (
      .clk_i(clk), .rst_i(rst), .wr_data_i(wr_data), .wr_en_i(wr_en), .err_cnt_clr_i(clr),
      .rd_data_o(rds), .rd_error_o(errs), .csr_new_maj_err_o(majs), .csr_new_min_err_o(mins),
      .csr_scrub_occurred_o(scrs), .err_cnt_o(cnts));

   typedef struct {
      logic        we;
      logic [31:0] d;
      logic [31:0] exp;
   } vec_t;

   vec_t vecs[6];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, want %h", name, act, exp);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      vecs[0] = '{1'b1, 32'h0000_0000, 32'h0000_0000};
      vecs[1] = '{1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
      vecs[2] = '{1'b0, 32'h1111_1111, 32'hFFFF_FFFF};
      vecs[3] = '{1'b1, 32'h8000_0001, 32'h8000_0001};
      vecs[4] = '{1'b1, 32'h5A5A_C3C3, 32'h5A5A_C3C3};
      vecs[5] = '{1'b0, 32'h0000_0000, 32'h5A5A_C3C3};

      rst = 1'b1; wr_en = 1'b0; wr_data = '0; clr = 1'b0;
      #2;
      chk("rst_rd2", rd2, RV);
      chk("rst_rd1", rd1, RV);
      chk("rst_err2", {31'b0, err2}, 0);
      chk("rst_err1", {31'b0, err1}, 0);
      chk("rst_pulses2", {29'b0, maj2, min2, scr2}, 0);
      chk("rst_cnt2", {24'b0, cnt2}, 0);
      @(negedge clk);
      rst = 1'b0;

      // Plain writes: one-cycle latency on every mode
      foreach (vecs[i]) begin
         wr_en = vecs[i].we; wr_data = vecs[i].d;
         @(negedge clk);
         chk("vec_rd2", rd2, vecs[i].exp);
         chk("vec_rd1", rd1, vecs[i].exp);
         chk("vec_rd0", rd0, vecs[i].exp);
         chk("vec_err2", {31'b0, err2}, 0);
         chk("vec_err1", {31'b0, err1}, 0);
      end
      wr_en = 1'b0;

      // Minor error: scrub back to the voted value
      wr_en = 1'b1; wr_data = 32'hA5A5_A5A5;
      @(negedge clk);
      wr_en = 1'b0;
      chk("min_rd_before", rd2, 32'hA5A5_A5A5);
      u_m2.copy1_q <= u_m2.copy1_q ^ 32'h1;
      #1;
      chk("min_no_early_pulse", {31'b0, min2}, 0);
      @(negedge clk);
      chk("min_pulse", {31'b0, min2}, 1);
      chk("min_scrub_not_yet", {31'b0, scr2}, 0);
      chk("min_rd_during", rd2, 32'hA5A5_A5A5);
      chk("min_cnt_before", {24'b0, cnt2}, 0);
      @(negedge clk);
      chk("min_pulse_gone", {31'b0, min2}, 0);
      chk("scrub_pulse", {31'b0, scr2}, 1);
      chk("scrub_cnt", {24'b0, cnt2}, 1);
      chk("scrub_copy0", u_m2.copy0_q, 32'hA5A5_A5A5);
      chk("scrub_copy1", u_m2.copy1_q, 32'hA5A5_A5A5);
      chk("scrub_copy2", u_m2.copy2_q, 32'hA5A5_A5A5);
      chk("scrub_rd", rd2, 32'hA5A5_A5A5);
      @(negedge clk);
      chk("scrub_pulse_gone", {31'b0, scr2}, 0);

      // Major error in triple mode and shadow corruption in duplex mode
      u_m2.copy0_q <= u_m2.copy0_q ^ 32'h08;
      u_m2.copy2_q <= u_m2.copy2_q ^ 32'h80;
      u_m1.copy1_q <= u_m1.copy1_q ^ 32'h20;
      #1;
      chk("maj_err2_comb", {31'b0, err2}, 1);
      chk("maj_err1_comb", {31'b0, err1}, 1);
      chk("maj_no_early_pulse", {31'b0, maj2}, 0);
      @(negedge clk);
      chk("maj_pulse2", {31'b0, maj2}, 1);
      chk("maj_pulse1", {31'b0, maj1}, 1);
      chk("maj_no_min2", {31'b0, min2}, 0);
      chk("maj_no_min1", {31'b0, min1}, 0);
      chk("maj_rd2_voted", rd2, 32'hA5A5_A5A5);
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         chk("lock_maj2_once", {31'b0, maj2}, 0);
         chk("lock_maj1_once", {31'b0, maj1}, 0);
         chk("lock_err2", {31'b0, err2}, 1);
         chk("lock_err1", {31'b0, err1}, 1);
         chk("lock_no_scrub2", {30'b0, scr2, min2}, 0);
         chk("lock_no_scrub1", {30'b0, scr1, min1}, 0);
      end
      wr_en = 1'b1; wr_data = 32'h0;
      @(negedge clk);
      wr_en = 1'b0;
      chk("unlock_err2", {31'b0, err2}, 0);
      chk("unlock_err1", {31'b0, err1}, 0);
      chk("unlock_rd2", rd2, 32'h0);
      chk("unlock_rd1", rd1, 32'h0);
      chk("unlock_cnt2", {24'b0, cnt2}, 1);

      // Write in the same cycle as a minor fault wins
      wr_en = 1'b1; wr_data = 32'h1234;
      u_m2.copy1_q <= u_m2.copy1_q ^ 32'h4;
      @(negedge clk);
      wr_en = 1'b0;
      chk("wrmin_rd", rd2, 32'h1234);
      chk("wrmin_min", {31'b0, min2}, 0);
      chk("wrmin_err", {31'b0, err2}, 0);
      chk("wrmin_cnt", {24'b0, cnt2}, 1);
      @(negedge clk);
      chk("wrmin_no_pulses", {29'b0, maj2, min2, scr2}, 0);
      chk("wrmin_rd_hold", rd2, 32'h1234);

      // Saturating 2-bit counter, then clear beats a same-cycle increment
      for (int k = 0; k < 4; k++) begin
         u_sat.copy2_q <= u_sat.copy2_q ^ (32'h1 << k);
         @(negedge clk);
         chk("sat_min", {31'b0, mins}, 1);
         @(negedge clk);
         chk("sat_cnt", {30'b0, cnts}, (k < 3) ? k + 1 : 3);
         chk("sat_rd", rds, 32'h1234);
      end
      u_sat.copy0_q <= u_sat.copy0_q ^ 32'h100;
      @(negedge clk);
      chk("clr_min", {31'b0, mins}, 1);
      clr = 1'b1;
      @(negedge clk);
      clr = 1'b0;
      chk("clr_cnt", {30'b0, cnts}, 0);
      chk("clr_scrub", {31'b0, scrs}, 1);

      // Reset asserted mid-scrub
      u_m2.copy0_q <= u_m2.copy0_q ^ 32'h200;
      @(negedge clk);
      chk("rstscr_min", {31'b0, min2}, 1);
      rst = 1'b1;
      #1;
      chk("rstscr_min_off", {31'b0, min2}, 0);
      chk("rstscr_pulses", {29'b0, maj2, scr2, err2}, 0);
      chk("rstscr_rd", rd2, RV);
      chk("rstscr_cnt", {24'b0, cnt2}, 0);
      @(negedge clk);
      chk("rstscr_held", {28'b0, maj2, min2, scr2, err2}, 0);
      rst = 1'b0;
      @(negedge clk);
      chk("rstscr_after", {28'b0, maj2, min2, scr2, err2}, 0);
      chk("rstscr_rd_after", rd2, RV);
      @(negedge clk);
      chk("rstscr_idle", {28'b0, maj2, min2, scr2, err2}, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/ibex_csr_redundant.md
IBEX_CSR_REDUNDANT -- requirements
Module: ibex_csr_redundant

Interface
REQ-001 SHALL have parameter Width, default 32, CSR data width in bits (1..64).
REQ-002 SHALL have parameter RedMode, default 2: 0 = single copy, 1 = shadow (duplex, detect only), 2 = triple copy (majority vote plus scrub).
REQ-003 SHALL have parameter ResetValue, default '0, Width bits, reset content of every primary copy.
REQ-004 SHALL have parameter ErrCntWidth, default 8, width of the saturating minor-error counter (2..16).
REQ-005 SHALL have port clk_i  input  1  sole clock; all state updates on its rising edge.
REQ-006 SHALL have port rst_i  input  1  reset, asynchronous and active-high.
REQ-007 SHALL have port wr_data_i  input  Width  write data.
REQ-008 SHALL have port wr_en_i  input  1  write strobe; all copies load on the same edge.
REQ-009 SHALL have port err_cnt_clr_i  input  1  synchronous clear of err_cnt_o.
REQ-010 SHALL have port rd_data_o  output  Width  read data: copy 0 (modes 0/1) or bitwise majority of copies 0..2 (mode 2).
REQ-011 SHALL have port rd_error_o  output  1  stored value untrustworthy.
REQ-012 SHALL have port csr_new_maj_err_o  output  1  one-cycle pulse on an uncorrectable error.
REQ-013 SHALL have port csr_new_min_err_o  output  1  one-cycle pulse on a correctable error.
REQ-014 SHALL have port csr_scrub_occurred_o  output  1  one-cycle pulse after a scrub write completes.
REQ-015 SHALL have port err_cnt_o  output  ErrCntWidth  count of minor errors, saturating.

Function
REQ-016 SHALL store copies as follows: mode 1 keeps copy 0 plus a shadow holding the bitwise inverse of the data; mode 2 keeps copies 0..2, all non-inverted.
REQ-017 SHALL define minor (mode 2 only) as exactly one copy differing from the vote in one or more bits.
REQ-018 SHALL define major as: mode 1, copy0 != ~shadow; mode 2, two or more copies each differing from the vote in some bit.
REQ-019 SHALL tie rd_error_o, all three pulses and err_cnt_o to 0 in mode 0, with no FSM.
REQ-020 SHALL implement an FSM with states IDLE, SCRUB and LOCKED, evaluated only when wr_en_i = 0.
REQ-021 SHALL transition IDLE -> SCRUB on minor, and IDLE -> LOCKED on major; major wins when both hold.
REQ-022 SHALL, in SCRUB, load every copy with the current vote at the end of that cycle, then return to IDLE unconditionally.
REQ-023 SHALL hold LOCKED until wr_en_i = 1; no scrub occurs in LOCKED.
REQ-024 SHALL, on wr_en_i = 1 in any state, load all copies and move to IDLE on the next edge; a pending scrub is cancelled and no pulse is generated.
REQ-025 SHALL drive csr_new_min_err_o = 1 exactly during the SCRUB cycle.
REQ-026 SHALL drive csr_new_maj_err_o = 1 only during the first LOCKED cycle.
REQ-027 SHALL register csr_scrub_occurred_o, asserting it in the cycle after SCRUB.
REQ-028 SHALL drive rd_error_o = 1 whenever state = LOCKED, or whenever major holds combinationally.
REQ-029 SHALL give writes a latency of 1: data written at edge N appears on rd_data_o in cycle N+1.
REQ-030 SHALL increment err_cnt_o once per SCRUB entry, holding at 2^ErrCntWidth-1.
REQ-031 SHALL give err_cnt_clr_i priority over a same-cycle increment; the result is 0.

Reset
REQ-032 SHALL, while rst_i = 1 (asynchronously), set copies to ResetValue, the shadow to ~ResetValue, state to IDLE, and err_cnt_o to 0.
REQ-033 SHALL hold every output pulse and rd_error_o at 0 during reset.
REQ-034 SHALL abort any scrub in progress when reset is asserted mid-SCRUB.

Verification
REQ-035 SHALL cover: mode 2, write 0xA5A5A5A5, then force copy1 bit 0 flipped -> new_min pulse in 1 cycle, scrub pulse the cycle after, all copies equal 0xA5A5A5A5, err_cnt = 1, rd_data constant.
REQ-036 SHALL cover: mode 2, flip bit 3 of copy0 and bit 7 of copy2 together -> one new_maj pulse, rd_error held; then write 0x0 -> rd_error = 0 on the next cycle.
REQ-037 SHALL cover: mode 1, corrupt the shadow -> rd_error = 1, one new_maj pulse, no scrub; holds until a write.
REQ-038 SHALL cover: mode 2, inject minor with wr_en_i = 1 and data 0x1234 on the same cycle -> no pulses, rd_data = 0x1234 next cycle, err_cnt unchanged.
REQ-039 SHALL cover: ErrCntWidth = 2, four minor events -> counter reads 3; assert err_cnt_clr_i in the same cycle as a fifth SCRUB -> counter reads 0.
REQ-040 SHALL cover: assert rst_i mid-SCRUB -> outputs 0 immediately, rd_data = ResetValue, state IDLE after release.
